// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin request/acknowledge arbiter that shares one
// single-port 256x8 block RAM between two requesters. Each transaction takes
// three cycles: grant/register the command (IDLE), let the RAM sample it
// (ISSUE), then collect the registered RAM output and acknowledge (CAPTURE).
module bram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0] state;
  // Priority pointer: 0 = port 0 wins a tie, 1 = port 1 wins a tie.
  logic       prio;
  // Remembers whether the transaction in flight is a write, since mem_rw
  // is dropped after the RAM has sampled it.
  logic       op_wr;

  logic elig0;
  logic elig1;
  logic pick1;
  logic grant_any;

  // Arbitration: a port whose ack is on the wire this cycle is masked so a
  // held request cannot be re-granted on the acknowledge edge.
  always_comb begin
    elig0     = req0 & ~ack0;
    elig1     = req1 & ~ack1;
    grant_any = elig0 | elig1;
    pick1     = elig1 & (~elig0 | prio);
  end

  assign busy = (state != IDLE);

  // Three-state transaction sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (grant_any) state <= ISSUE;
        ISSUE:   state <= CAPTURE;
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM command registers: loaded on grant; mem_rw is a single-cycle strobe
  // so the RAM sees harmless reads at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      mem_data <= '0;
      mem_rw   <= 1'b0;
      op_wr    <= 1'b0;
    end else begin
      mem_rw <= 1'b0;
      if (state == IDLE && grant_any) begin
        mem_addr <= pick1 ? addr1  : addr0;
        mem_data <= pick1 ? wdata1 : wdata0;
        mem_rw   <= pick1 ? rw1    : rw0;
        op_wr    <= pick1 ? rw1    : rw0;
      end
    end
  end

  // Owner indication: set on grant, cleared when the transaction completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= 2'b00;
    end else if (state == IDLE && grant_any) begin
      gnt <= pick1 ? 2'b10 : 2'b01;
    end else if (state == CAPTURE) begin
      gnt <= 2'b00;
    end
  end

  // One-cycle acknowledge to the owner on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= (state == CAPTURE) & gnt[0];
      ack1 <= (state == CAPTURE) & gnt[1];
    end
  end

  // Read-data capture: only reads update the owner's result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == CAPTURE && !op_wr) begin
      if (gnt[0]) rdata0 <= mem_out;
      if (gnt[1]) rdata1 <= mem_out;
    end
  end

  // Round-robin pointer: after each transaction the other port gets priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (state == CAPTURE) begin
      prio <= gnt[0];
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: a behavioural 256x8 RAM with registered output,
// a transaction-level reference (shadow memory, round-robin pointer, expected
// acknowledge latencies) and directed plus randomized accesses.
module tb_bram_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              req0, req1, rw0, rw1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [1:0]        gnt;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_out;

  bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt(gnt), .busy(busy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_rw(mem_rw),
    .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: registered output, forced to 0 in write mode.
  logic [7:0] ram [256];
  logic [7:0] ram_q = 8'h00;
  logic       ram_init;
  int         wr_cnt = 0;
  assign mem_out = ram_q;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
    end else if (mem_rw) begin
      ram[mem_addr] <= mem_data;
      ram_q <= 8'h00;
    end else begin
      ram_q <= ram[mem_addr];
    end
  end

  always @(posedge clk) if (mem_rw) wr_cnt <= wr_cnt + 1;

  // Reference state
  logic [7:0] shadow [256];
  logic [7:0] exp_rdata [2];
  logic       mprio;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_gnt"},      32'(gnt),      32'h0);
    check({pfx, "_busy"},     32'(busy),     32'h0);
    check({pfx, "_ack0"},     32'(ack0),     32'h0);
    check({pfx, "_ack1"},     32'(ack1),     32'h0);
    check({pfx, "_rdata0"},   32'(rdata0),   32'h0);
    check({pfx, "_rdata1"},   32'(rdata1),   32'h0);
    check({pfx, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({pfx, "_mem_data"}, 32'(mem_data), 32'h0);
    check({pfx, "_mem_rw"},   32'(mem_rw),   32'h0);
  endtask

  // One access per enabled port, all raised together. The model orders the
  // accesses by the round-robin rule and predicts results and latencies.
  task automatic run(input string tag, input logic e0, input logic e1,
                     input logic w0, input logic w1,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1);
    int         exp_t [2];
    int         got_t [2];
    logic       en [2];
    logic       w [2];
    logic [7:0] a [2];
    logic [7:0] d [2];
    int         first, p, nwr, wr0;
    en[0] = e0; en[1] = e1; w[0] = w0; w[1] = w1;
    a[0] = a0;  a[1] = a1;  d[0] = d0; d[1] = d1;
    exp_t[0] = -1; exp_t[1] = -1; got_t[0] = -1; got_t[1] = -1;
    first = (e0 && e1) ? (mprio ? 1 : 0) : (e0 ? 0 : 1);
    nwr = 0;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : 1 - first;
      if (en[p]) begin
        exp_t[p] = (k == 0) ? 3 : 6;
        if (w[p]) begin
          shadow[a[p]] = d[p];
          nwr++;
        end else begin
          exp_rdata[p] = shadow[a[p]];
        end
        mprio = (p == 0);
      end
    end
    wr0 = wr_cnt;
    req0 = e0; rw0 = w0; addr0 = a0; wdata0 = d0;
    req1 = e1; rw1 = w1; addr1 = a1; wdata1 = d1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check({tag, "_gnt"},  32'(gnt),  32'(first == 0 ? 2'b01 : 2'b10));
        check({tag, "_busy"}, 32'(busy), 32'h1);
      end
      if (req0 && ack0) begin
        got_t[0] = n;
        req0 = 1'b0;
        check({tag, "_rdata0"}, 32'(rdata0), 32'(exp_rdata[0]));
      end
      if (req1 && ack1) begin
        got_t[1] = n;
        req1 = 1'b0;
        check({tag, "_rdata1"}, 32'(rdata1), 32'(exp_rdata[1]));
      end
      if (!req0 && !req1) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    for (int q = 0; q < 2; q++)
      if (en[q]) check($sformatf("%s_lat%0d", tag, q), 32'(got_t[q]), 32'(exp_t[q]));
    check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(nwr));
    check({tag, "_idle"},   32'({gnt, busy}), 32'h0);
  endtask

  // Both ports hold read requests; each drops only after four grants have
  // been seen and its own ack arrives. Expect five alternating grants.
  task automatic hold_both(input logic [7:0] a0, input logic [7:0] a1);
    logic [1:0] grants [$];
    logic [1:0] prev;
    logic       p;
    p = mprio;
    prev = 2'b00;
    req0 = 1'b1; rw0 = 1'b0; addr0 = a0;
    req1 = 1'b1; rw1 = 1'b0; addr1 = a1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (gnt != 2'b00 && prev == 2'b00) grants.push_back(gnt);
      prev = gnt;
      if (req0 && ack0) begin
        check("hold_rdata0", 32'(rdata0), 32'(shadow[a0]));
        if (grants.size() >= 4) req0 = 1'b0;
      end
      if (req1 && ack1) begin
        check("hold_rdata1", 32'(rdata1), 32'(shadow[a1]));
        if (grants.size() >= 4) req1 = 1'b0;
      end
      if (!req0 && !req1) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("hold_ngrants", 32'(grants.size()), 32'd5);
    for (int i = 0; i < grants.size() && i < 5; i++)
      check($sformatf("hold_gnt%0d", i), 32'(grants[i]),
            32'(((p ^ i[0]) == 1'b0) ? 2'b01 : 2'b10));
    exp_rdata[0] = shadow[a0];
    exp_rdata[1] = shadow[a1];
    mprio = ~p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int got;
    logic [1:0] pat;
    rst_n = 1'b0; ram_init = 1'b1;
    req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i);
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    mprio = 1'b0;

    // Reset values
    @(negedge clk);
    ram_init = 1'b0;
    @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("post_rst");

    // Single read
    run("rd2a", 1'b1, 1'b0, 1'b0, 1'b0, 8'h2A, 8'h00, 8'h00, 8'h00);
    check("rd2a_value", 32'(rdata0), 32'h2A);

    // Write then read-back on port 1
    run("wr10", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h10, 8'h00, 8'hC3);
    run("rb10", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 8'h00, 8'h00);
    check("rb10_value",  32'(rdata1), 32'hC3);
    check("rb10_rdata0", 32'(rdata0), 32'h2A);

    // Contention, then continuous requests
    run("cont", 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h06, 8'h00, 8'h00);
    check("cont_rd0", 32'(rdata0), 32'h05);
    check("cont_rd1", 32'(rdata1), 32'h06);
    hold_both(8'h05, 8'h06);

    // Priority rotation
    run("rot_p1",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h33, 8'h00, 8'h00);
    run("rot_tie", 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 8'h55, 8'h00, 8'h00);
    run("rot_tie2", 1'b1, 1'b1, 1'b0, 1'b0, 8'h46, 8'h57, 8'h00, 8'h00);

    // Reset in the middle of a write
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h20; wdata0 = 8'hFF;
    @(negedge clk);
    check("rstw_gnt",    32'(gnt),    32'h1);
    check("rstw_mem_rw", 32'(mem_rw), 32'h1);
    wr0 = wr_cnt;
    rst_n = 1'b0; req0 = 1'b0; rw0 = 1'b0;
    #1;
    check_reset_state("rstw");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_lost_write", 32'(wr_cnt - wr0), 32'h0);
    mprio = 1'b0;
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    run("rstw_rd", 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h00);
    check("rstw_rd_value", 32'(rdata0), 32'h20);

    // Request held through its ack
    exp_rdata[0] = shadow[8'h77];
    mprio = 1'b1;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h77;
    got = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 4) begin
        check("b2b_nodup_gnt",  32'(gnt),  32'h0);
        check("b2b_nodup_busy", 32'(busy), 32'h0);
      end
      if (n == 5) check("b2b_regrant", 32'(gnt), 32'h1);
      if (ack0) begin
        got++;
        check("b2b_rdata0", 32'(rdata0), 32'(exp_rdata[0]));
        if (got == 2) begin
          check("b2b_ack2_time", 32'(n), 32'd7);
          req0 = 1'b0;
          break;
        end
      end
    end
    req0 = 1'b0;
    @(negedge clk);
    check("b2b_acks", 32'(got), 32'd2);

    // Randomized accesses over a small address window to force collisions
    for (int i = 0; i < 24; i++) begin
      pat = 2'($urandom_range(1, 3));
      run($sformatf("rnd%0d", i), pat[0], pat[1],
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-port request/acknowledge arbiter that shares the single-port 256x8 block RAM between two independent requesters, e.g. the switch/UI path and an internal fill/scan engine. It grants one requester at a time in round-robin order, drives the RAM's clk-synchronous address/data/readWrite inputs, and captures the RAM's registered output. It returns read data and a one-cycle acknowledge to the owner of each transaction.

## Interface
- ADDR_W, 8, RAM address width (256 words)
- DATA_W, 8, RAM data width
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1  access request from requester 0/1; held until the matching ack
- rw0, rw1  in  1  0 = read, 1 = write (RAM readWrite encoding); stable while req is high
- addr0, addr1  in  ADDR_W  access address; stable while req is high
- wdata0, wdata1  in  DATA_W  write data; stable while req is high
- ack0, ack1  out  1  one-cycle pulse: transaction of that requester complete
- rdata0, rdata1  out  DATA_W  read result, valid while ackN is high; holds until the next read by that port
- gnt  out  2  one-hot current owner, 00 when idle
- busy  out  1  high whenever state != IDLE
- mem_addr  out  ADDR_W  to RAM addr
- mem_data  out  DATA_W  to RAM data
- mem_rw  out  1  to RAM readWrite
- mem_out  in  DATA_W  from RAM out, registered in RAM, 1-cycle read latency

## Operation
- Reset values: state IDLE, gnt 00, busy 0, ack0/ack1 0, rdata0/rdata1 0, mem_addr 0, mem_data 0, mem_rw 0, priority pointer = port 0.
- Reset is asynchronous: it aborts any transaction immediately, forces mem_rw to 0 and drops gnt. A write not yet sampled by the RAM is lost. RAM contents are never reset.
- FSM has three states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - The eligible set is reqN high and ackN low. A port being acknowledged this cycle is masked.
  - If no port is eligible, stay in IDLE.
  - One eligible port: grant it.
  - Both eligible: grant the port named by the priority pointer.
  - On grant: register addrN into mem_addr, wdataN into mem_data and rwN into mem_rw; set gnt one-hot and go to ISSUE.
- ISSUE: the RAM samples mem_* on this edge. Set mem_rw to 0 and go to CAPTURE. mem_addr and mem_data hold their values.
- CAPTURE:
  - mem_out is valid for a read. On a write it reads 0, which the RAM forces in write mode.
  - On this edge pulse ackN for the owner.
  - If it was a read, load rdataN from mem_out. A write leaves rdataN unchanged.
  - Point the priority pointer at the other port, clear gnt and return to IDLE.
- mem_rw is high for exactly one cycle per write and 0 at all other times. Idle cycles therefore present harmless reads.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1. Neither port waits more than one foreign transaction.
- Requester rule: drop reqN, or change command, in the cycle after ackN is seen. A request still high after ack starts a new transaction. It is serviced only after the other port if that port is waiting.

## Timing
- Latency: from reqN sampled high in IDLE (edge E0) to ackN high is 3 edges. Grant at E0, RAM access at E1, ack and rdata at E2, ack visible in the cycle after E2.
- Throughput: one transaction per 3 cycles. IDLE is re-entered on the same edge ack rises, so a new grant can occur at E2+1.
- Write visibility: data written at E1 is returned by any read granted at E2+1 or later.
- gnt and busy are high from E0 to E2.
- Simultaneous requests in IDLE: only the pointer port is granted. The other stays pending with no ack and no lost request.
- A request arriving during ISSUE or CAPTURE is sampled at the next IDLE edge.

## Test plan
- Reset, then a single read: RAM preloaded with word i at address i. req0=1, rw0=0, addr0=0x2A. Expect gnt=01, ack0 3 cycles later with rdata0=0x2A, and mem_rw never high.
- Write then read-back: port 1 writes 0xC3 to 0x10, then reads 0x10. Expect mem_rw high exactly one cycle, ack1 twice, rdata1=0xC3, rdata0 unchanged.
- Contention: req0 and req1 rise on the same cycle, reads of 0x05 and 0x06. Expect port 0 served first (ack0 with 0x05), then port 1 (ack1 with 0x06). Holding both requests gives gnt sequence 01,10,01,10.
- Priority rotation: after a port-1 access, both request. Expect port 0 granted; port 1 wins the next tie.
- Reset mid-write: assert rst_n=0 while in ISSUE before E1 for a write of 0xFF to 0x20. Expect mem_rw=0 immediately, all outputs at reset values, and a later read of 0x20 returns 0x20.
- Back-to-back ack masking: req0 held high through ack0. Expect no duplicate grant in the ack cycle, then a second port-0 transaction starting the following cycle.
